pmem_arbiter_rr: RTL and testbench
==================================

PMEM_ARBITER_RR -- requirements
Module: pmem_arbiter_rr

Interface
REQ-001 Parameter NUM_CH, default 2, range 2..8: number of requesting cache channels.
REQ-002 Parameter ADDR_W, default 32: physical address width.
REQ-003 Parameter LINE_W, default 256: cache-line data width.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 ch_read  in  NUM_CH  per-channel line-read request, held until its ch_resp.
REQ-007 ch_write  in  NUM_CH  per-channel line-write request, held until its ch_resp.
REQ-008 ch_addr  in  NUM_CH*ADDR_W  per-channel address; channel i at bits [i*ADDR_W +: ADDR_W].
REQ-009 ch_wdata  in  NUM_CH*LINE_W  per-channel write line, packed the same way.
REQ-010 ch_resp  out  NUM_CH  one-hot completion pulse to the granted channel.
REQ-011 ch_rdata  out  LINE_W  memory read line, broadcast to all channels.
REQ-012 mem_read / mem_write  out  1 each  request to physical memory.
REQ-013 mem_addr  out  ADDR_W; mem_wdata  out  LINE_W  granted channel's address/data.
REQ-014 mem_resp  in  1; mem_rdata  in  LINE_W  memory completion and read line.
REQ-015 grant_valid  out  1; grant_idx  out  $clog2(NUM_CH)  current owner, for debug/perf.

Function
REQ-016 The FSM SHALL have exactly two states: IDLE and BUSY.
REQ-017 In IDLE with any channel requesting (read or write), the arbiter SHALL register a grant index and go to BUSY on the next edge; with no requests it SHALL stay in IDLE.
REQ-018 Selection SHALL be round-robin: search starts at (last_grant+1) mod NUM_CH, wraps, and grants the first requesting channel.
REQ-019 The last_grant pointer SHALL update only on grant, so a lone requester may be granted back-to-back.
REQ-020 At grant, the op SHALL be latched; if ch_read and ch_write are both high on that channel, read SHALL win.
REQ-021 In BUSY, mem_read or mem_write (per latched op) SHALL be held high, and mem_addr/mem_wdata SHALL be driven from the granted channel every cycle.
REQ-022 In BUSY, ch_resp[grant_idx] SHALL equal mem_resp combinationally; all other ch_resp bits SHALL be 0.
REQ-023 On mem_resp in BUSY, the FSM SHALL return to IDLE on the next edge; mem_read/mem_write SHALL be 0 in IDLE.
REQ-024 Grant latency SHALL be one cycle: request visible in IDLE at cycle t, memory request asserted at t+1.
REQ-025 Requests arriving or dropping during BUSY SHALL NOT change grant_idx, op, or memory strobes until return to IDLE.
REQ-026 mem_resp in IDLE SHALL be ignored: no ch_resp, no state change.
REQ-027 ch_rdata SHALL equal mem_rdata at all times.
REQ-028 grant_valid SHALL be 1 exactly in BUSY; grant_idx SHALL hold the last grant in IDLE.

Reset
REQ-029 Asserting rst SHALL immediately force IDLE, last_grant = NUM_CH-1 (so channel 0 wins first), grant_idx = 0, latched op = read.
REQ-030 During reset, mem_read, mem_write, ch_resp and grant_valid SHALL be 0.
REQ-031 Reset mid-transaction SHALL abandon it silently; no ch_resp SHALL be issued for it.

Configuration
REQ-032 Macro PMEM_ARB_CH0_PRIORITY_EN SHALL select the grant policy.
REQ-033 With PMEM_ARB_CH0_PRIORITY_EN defined, channel 0 SHALL win whenever requesting in IDLE; other channels SHALL use round-robin among themselves, and a channel-0 grant SHALL NOT move last_grant.
REQ-034 Without the macro, pure round-robin over all NUM_CH channels SHALL apply (REQ-018).

Verification
REQ-035 Reset, NUM_CH=2; ch_read=2'b11 held -> grant ch0 first, ch1 next, alternating 0,1,0,1 over four transactions.
REQ-036 NUM_CH=4, only ch2 read at 0x1000, mem_resp after 5 cycles -> mem_read high cycles 1..6, mem_addr=0x1000, single ch_resp[2] pulse aligned with mem_resp.
REQ-037 ch1 ch_read and ch_write both high -> mem_read=1, mem_write=0.
REQ-038 ch0 drops its request mid-BUSY while ch1 asserts -> mem strobe and grant_idx=0 unchanged until mem_resp; ch1 granted the cycle after.
REQ-039 rst asserted in BUSY mid-cycle -> mem_read/mem_write drop to 0 without a clock edge; no ch_resp; first grant after release goes to ch0.
REQ-040 With PMEM_ARB_CH0_PRIORITY_EN, NUM_CH=3, all channels requesting continuously -> ch0 wins every transaction; with ch0 idle, ch1 and ch2 alternate.

Source files
------------

// File: rtl/pmem_arbiter_rr_if.sv
// Channel-side and memory-side bundle for the physical-memory arbiter.
// Latency: none (wires only).
// Backpressure: none here; channels hold requests until their ch_resp pulse.
interface pmem_arbiter_rr_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    localparam int IDX_W = $clog2(NUM_CH);

    // Cache-channel side
    logic [NUM_CH-1:0]        ch_read;
    logic [NUM_CH-1:0]        ch_write;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*LINE_W-1:0] ch_wdata;
    logic [NUM_CH-1:0]        ch_resp;
    logic [LINE_W-1:0]        ch_rdata;

    // Physical-memory side
    logic                     mem_read;
    logic                     mem_write;
    logic [ADDR_W-1:0]        mem_addr;
    logic [LINE_W-1:0]        mem_wdata;
    logic                     mem_resp;
    logic [LINE_W-1:0]        mem_rdata;

    // Debug / performance visibility
    logic                     grant_valid;
    logic [IDX_W-1:0]         grant_idx;

    // Requesters and memory model drive this side
    modport master (
        output ch_read, ch_write, ch_addr, ch_wdata, mem_resp, mem_rdata,
        input  ch_resp, ch_rdata, mem_read, mem_write, mem_addr, mem_wdata,
        input  grant_valid, grant_idx
    );

    // The arbiter itself
    modport slave (
        input  ch_read, ch_write, ch_addr, ch_wdata, mem_resp, mem_rdata,
        output ch_resp, ch_rdata, mem_read, mem_write, mem_addr, mem_wdata,
        output grant_valid, grant_idx
    );
endinterface

// File: rtl/pmem_arbiter_rr.sv
// Round-robin arbiter of NUM_CH cache channels onto one physical memory port; PMEM_ARB_CH0_PRIORITY_EN gives ch0 absolute priority.
// Latency: request seen in IDLE at cycle t -> memory strobe at t+1; ch_resp is combinational from mem_resp.
// Backpressure: one transaction in flight; other channels hold their requests until granted and completed.
module pmem_arbiter_rr #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic clk,
    input  logic rst,
    pmem_arbiter_rr_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_CH);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic               op_write_q, op_write_d;

    logic [NUM_CH-1:0]  req;
    logic [NUM_CH-1:0]  rr_req;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W-1:0]   cand;
    logic               found;
    logic               move_last;
    logic               busy;

    // Pick the next owner: rotate from last_grant+1, first requester wins
    always_comb begin
        req       = bus.ch_read | bus.ch_write;
        rr_req    = req;
        sel       = '0;
        cand      = '0;
        found     = 1'b0;
        move_last = 1'b1;
`ifdef PMEM_ARB_CH0_PRIORITY_EN
        // ch0 is taken out of the rotation and overrides it below
        rr_req[0] = 1'b0;
`endif
        for (int off = 1; off <= NUM_CH; off++) begin
            cand = IDX_W'((int'(last_grant_q) + off) % NUM_CH);
            if (!found && rr_req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
`ifdef PMEM_ARB_CH0_PRIORITY_EN
        // A ch0 grant leaves the rotation pointer where the others left it
        if (req[0]) begin
            found     = 1'b1;
            sel       = '0;
            move_last = 1'b0;
        end
`endif
    end

    // Next-state: grant from IDLE, release on mem_resp in BUSY
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_idx_d  = grant_idx_q;
        op_write_d   = op_write_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d     = BUSY;
                    grant_idx_d = sel;
                    // Read wins when a channel raises both
                    op_write_d  = !bus.ch_read[sel];
                    if (move_last) begin
                        last_grant_d = sel;
                    end
                end
            end
            BUSY: begin
                if (bus.mem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(NUM_CH - 1);
            grant_idx_q  <= '0;
            op_write_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_idx_q  <= grant_idx_d;
            op_write_q   <= op_write_d;
        end
    end

    // Outputs follow the registered owner; strobes only while BUSY
    always_comb begin
        busy                  = (state_q == BUSY);
        bus.mem_read          = busy && !op_write_q;
        bus.mem_write         = busy && op_write_q;
        bus.mem_addr          = bus.ch_addr[int'(grant_idx_q)*ADDR_W +: ADDR_W];
        bus.mem_wdata         = bus.ch_wdata[int'(grant_idx_q)*LINE_W +: LINE_W];
        bus.ch_rdata          = bus.mem_rdata;
        bus.grant_valid       = busy;
        bus.grant_idx         = grant_idx_q;
        bus.ch_resp           = '0;
        if (busy && bus.mem_resp) begin
            bus.ch_resp[grant_idx_q] = 1'b1;
        end
    end
endmodule

// File: tb/tb_pmem_arbiter_rr.sv
module tb_pmem_arbiter_rr;
    localparam int NUM_CH = 4;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   cmp_en = 1'b0;

    pmem_arbiter_rr_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus();

    pmem_arbiter_rr #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit                m_busy  = 1'b0;
    int                m_owner = 0;
    bit                m_write = 1'b0;
    int                m_last  = NUM_CH - 1;
    logic [NUM_CH-1:0] m_req;
    int                m_g;
    bit                m_mv;
    logic [NUM_CH-1:0] e_resp;

    // Order of search is the list last+1, last+2, ... wrapping; first requester wins.
    function automatic int pick(input logic [NUM_CH-1:0] req_in, input int last, output bit moves);
        int order[$];
        logic [NUM_CH-1:0] r;
        r = req_in;
        moves = 1'b1;
`ifdef PMEM_ARB_CH0_PRIORITY_EN
        if (r[0]) begin
            moves = 1'b0;
            return 0;
        end
        r[0] = 1'b0;
`endif
        for (int k = 1; k <= NUM_CH; k++) order.push_back((last + k) % NUM_CH);
        foreach (order[j]) if (r[order[j]]) return order[j];
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 1'b0; m_owner = 0; m_write = 1'b0; m_last = NUM_CH - 1;
        end else if (!m_busy) begin
            m_req = bus.ch_read | bus.ch_write;
            m_g   = pick(m_req, m_last, m_mv);
            if (m_g >= 0) begin
                m_busy  = 1'b1;
                m_owner = m_g;
                m_write = !bus.ch_read[m_g];
                if (m_mv) m_last = m_g;
            end
        end else if (bus.mem_resp) begin
            m_busy = 1'b0;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            e_resp = '0;
            if (m_busy && bus.mem_resp) e_resp[m_owner] = 1'b1;
            check("mem_read",    bus.mem_read,    m_busy && !m_write);
            check("mem_write",   bus.mem_write,   m_busy && m_write);
            check("grant_valid", bus.grant_valid, m_busy);
            check("grant_idx",   bus.grant_idx,   m_owner);
            check("ch_resp",     bus.ch_resp,     e_resp);
            check("ch_rdata",    bus.ch_rdata,    bus.mem_rdata);
            if (m_busy) begin
                check("mem_addr",  bus.mem_addr,  bus.ch_addr[m_owner*ADDR_W +: ADDR_W]);
                check("mem_wdata", bus.mem_wdata, bus.ch_wdata[m_owner*LINE_W +: LINE_W]);
            end
        end
    end

    // Memory read data wanders every cycle
    always @(posedge clk) begin
        #2 bus.mem_rdata = {$urandom(), $urandom()};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a grant, then complete it after lat busy cycles.
    task automatic serve(input int lat, output int g);
        int n;
        n = 0;
        while (!bus.grant_valid && n < 20) begin
            tick();
            n++;
        end
        check("grant_arrived", bus.grant_valid, 1'b1);
        g = int'(bus.grant_idx);
        repeat (lat - 1) tick();
        bus.mem_resp = 1'b1;
        tick();
        bus.mem_resp = 1'b0;
    endtask

    int g;
    int exp_seq[4];

    initial begin
        bus.ch_read   = '0;
        bus.ch_write  = '0;
        bus.ch_addr   = '0;
        bus.ch_wdata  = '0;
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            bus.ch_addr[i*ADDR_W +: ADDR_W]  = 32'h100 * (i + 1);
            bus.ch_wdata[i*LINE_W +: LINE_W] = 64'hA5A5_0000_0000_0000 + 64'(i);
        end
        #2 rst = 1'b0;
        cmp_en = 1'b1;
        #1;
        check("rst_mem_read",    bus.mem_read,    1'b0);
        check("rst_mem_write",   bus.mem_write,   1'b0);
        check("rst_grant_valid", bus.grant_valid, 1'b0);
        check("rst_grant_idx",   bus.grant_idx,   2'd0);
        check("rst_ch_resp",     bus.ch_resp,     4'b0000);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Lone ch2 read at 0x1000, memory answers in the sixth busy cycle
        bus.ch_addr[2*ADDR_W +: ADDR_W] = 32'h1000;
        bus.ch_read = 4'b0100;
        for (int c = 1; c <= 6; c++) begin
            tick();
            check("s1_mem_read",  bus.mem_read,  1'b1);
            check("s1_mem_addr",  bus.mem_addr,  32'h1000);
            check("s1_grant_idx", bus.grant_idx, 2'd2);
            if (c == 6) begin
                bus.mem_resp = 1'b1;
                #1 check("s1_ch_resp", bus.ch_resp, 4'b0100);
            end else begin
                check("s1_no_resp", bus.ch_resp, 4'b0000);
            end
        end
        tick();
        bus.mem_resp = 1'b0;
        bus.ch_read  = '0;
        check("s1_idle_read", bus.mem_read, 1'b0);

        // ch0 and ch1 both hold reads: grants alternate
`ifdef PMEM_ARB_CH0_PRIORITY_EN
        exp_seq = '{0, 0, 0, 0};
`else
        exp_seq = '{0, 1, 0, 1};
`endif
        bus.ch_read = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            serve(1, g);
            check("s2_dut_grant",   g,       exp_seq[i]);
            check("s2_model_grant", m_owner, exp_seq[i]);
        end
        bus.ch_read = '0;
        tick();

        // ch1 raises read and write together: read wins
        bus.ch_read  = 4'b0010;
        bus.ch_write = 4'b0010;
        tick();
        check("s3_mem_read",  bus.mem_read,  1'b1);
        check("s3_mem_write", bus.mem_write, 1'b0);
        check("s3_grant",     bus.grant_idx, 2'd1);
        bus.mem_resp = 1'b1;
        tick();
        bus.mem_resp = 1'b0;
        bus.ch_read  = '0;
        bus.ch_write = '0;

        // ch3 write carries its line to memory
        bus.ch_write = 4'b1000;
        bus.ch_wdata[3*LINE_W +: LINE_W] = 64'hDEAD_BEEF_0123_4567;
        tick();
        check("s3_wr_strobe", bus.mem_write, 1'b1);
        check("s3_wr_read",   bus.mem_read,  1'b0);
        check("s3_wr_data",   bus.mem_wdata, 64'hDEAD_BEEF_0123_4567);
        check("s3_wr_grant",  bus.grant_idx, 2'd3);
        bus.mem_resp = 1'b1;
        tick();
        bus.mem_resp = 1'b0;
        bus.ch_write = '0;

        // ch0 drops mid-transaction while ch1 arrives: ownership is frozen
        bus.ch_read = 4'b0001;
        tick();
        check("s4_first_grant", bus.grant_idx, 2'd0);
        bus.ch_read = 4'b0010;
        repeat (2) begin
            tick();
            check("s4_hold_idx",  bus.grant_idx, 2'd0);
            check("s4_hold_read", bus.mem_read,  1'b1);
        end
        bus.mem_resp = 1'b1;
        tick();
        bus.mem_resp = 1'b0;
        check("s4_idle_gap", bus.grant_valid, 1'b0);
        tick();
        check("s4_next_valid", bus.grant_valid, 1'b1);
        check("s4_next_grant", bus.grant_idx,   2'd1);
        bus.mem_resp = 1'b1;
        tick();
        bus.mem_resp = 1'b0;
        bus.ch_read  = '0;

        // Stray mem_resp while idle is ignored
        bus.mem_resp = 1'b1;
        repeat (2) begin
            tick();
            check("s4b_no_resp",  bus.ch_resp,     4'b0000);
            check("s4b_no_valid", bus.grant_valid, 1'b0);
        end
        bus.mem_resp = 1'b0;
        tick();

        // Reset in the middle of a transaction
        bus.ch_read = 4'b1100;
        tick();
        check("s5_grant", bus.grant_idx, 2'd2);
        @(posedge clk);
        #3 rst = 1'b0;
        bus.mem_resp = 1'b1;
        #1;
        check("s5_rst_read",  bus.mem_read,    1'b0);
        check("s5_rst_write", bus.mem_write,   1'b0);
        check("s5_rst_resp",  bus.ch_resp,     4'b0000);
        check("s5_rst_valid", bus.grant_valid, 1'b0);
        bus.ch_read = 4'b1001;
        tick();
        rst = 1'b1;
        bus.mem_resp = 1'b0;
        tick();
        check("s5_after_valid", bus.grant_valid, 1'b1);
        check("s5_after_grant", bus.grant_idx,   2'd0);
        bus.mem_resp = 1'b1;
        tick();
        bus.mem_resp = 1'b0;
        bus.ch_read  = '0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
